// File: rtl/cache_axi_rd_arbiter.sv
// Read-channel arbiter that lets an instruction cache and a data cache
// share one AXI read port. Only one burst is in flight at a time. The
// AR request is granted round-robin, then the R beats are routed
// back to whichever cache owns the burst until the slave marks the
// last beat.
module cache_axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,

  // icache requester
  input  logic              ic_ar_valid,
  output logic              ic_ar_ready,
  input  logic [ADDR_W-1:0] ic_ar_addr,
  input  logic [LEN_W-1:0]  ic_ar_len,
  output logic              ic_r_valid,
  input  logic              ic_r_ready,
  output logic [DATA_W-1:0] ic_r_data,
  output logic              ic_r_last,

  // dcache requester
  input  logic              dc_ar_valid,
  output logic              dc_ar_ready,
  input  logic [ADDR_W-1:0] dc_ar_addr,
  input  logic [LEN_W-1:0]  dc_ar_len,
  output logic              dc_r_valid,
  input  logic              dc_r_ready,
  output logic [DATA_W-1:0] dc_r_data,
  output logic              dc_r_last,

  // shared AXI read master
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic [LEN_W-1:0]  m_ar_len,
  output logic              m_ar_id,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic              m_r_last
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Requester tags, also used as the value of the priority register.
  localparam logic ID_IC = 1'b0;
  localparam logic ID_DC = 1'b1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              prio;
  logic [ADDR_W-1:0] lat_addr;
  logic [LEN_W-1:0]  lat_len;
  logic              lat_id;

  logic              in_idle;
  logic              in_addr;
  logic              in_data;
  logic              gnt_ic;
  logic              gnt_dc;
  logic              own_r_ready;
  logic              beat_done;
  logic              burst_end;

  // Decode the current state into one-hot style qualifiers.
  always_comb begin
    in_idle = (state == ST_IDLE);
    in_addr = (state == ST_ADDR);
    in_data = (state == ST_DATA);
  end

  // Round-robin grant. A lone requester wins outright; on a tie the
  // priority register decides. Grants are suppressed while rst is high
  // because the latch registers are being cleared that cycle and the
  // requester would otherwise see an ar_ready for a request that is lost.
  always_comb begin
    gnt_ic = 1'b0;
    gnt_dc = 1'b0;
    if (in_idle && !rst) begin
      if (ic_ar_valid && dc_ar_valid) begin
        gnt_ic = (prio == ID_IC);
        gnt_dc = (prio == ID_DC);
      end else begin
        gnt_ic = ic_ar_valid;
        gnt_dc = dc_ar_valid;
      end
    end
  end

  // R-channel handshake seen through the current owner. The beat count
  // is never compared against len; only m_r_last ends a burst.
  always_comb begin
    own_r_ready = (lat_id == ID_DC) ? dc_r_ready : ic_r_ready;
    beat_done   = in_data && m_r_valid && own_r_ready;
    burst_end   = beat_done && m_r_last;
  end

  // Next-state logic for the IDLE -> ADDR -> DATA -> IDLE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (gnt_ic || gnt_dc) state_nxt = ST_ADDR;
      ST_ADDR: if (m_ar_ready)       state_nxt = ST_DATA;
      ST_DATA: if (burst_end)        state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority register: after each grant it points at the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= ID_IC;
    end else if (gnt_ic) begin
      prio <= ID_DC;
    end else if (gnt_dc) begin
      prio <= ID_IC;
    end
  end

  // Capture the winning request so the requester may drop or change its
  // inputs right after the grant without disturbing the AR phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr <= '0;
      lat_len  <= '0;
      lat_id   <= ID_IC;
    end else if (gnt_ic) begin
      lat_addr <= ic_ar_addr;
      lat_len  <= ic_ar_len;
      lat_id   <= ID_IC;
    end else if (gnt_dc) begin
      lat_addr <= dc_ar_addr;
      lat_len  <= dc_ar_len;
      lat_id   <= ID_DC;
    end
  end

  // AR channel toward the slave, driven only from the latched request.
  always_comb begin
    ic_ar_ready = gnt_ic;
    dc_ar_ready = gnt_dc;
    m_ar_valid  = in_addr;
    m_ar_addr   = lat_addr;
    m_ar_len    = lat_len;
    m_ar_id     = lat_id;
  end

  // R channel routing: only the owner sees valid/last, and only in DATA,
  // so stray beats outside a burst are neither accepted nor forwarded.
  always_comb begin
    m_r_ready  = in_data && own_r_ready;
    ic_r_valid = in_data && (lat_id == ID_IC) && m_r_valid;
    dc_r_valid = in_data && (lat_id == ID_DC) && m_r_valid;
    ic_r_last  = in_data && (lat_id == ID_IC) && m_r_last;
    dc_r_last  = in_data && (lat_id == ID_DC) && m_r_last;
    ic_r_data  = m_r_data;
    dc_r_data  = m_r_data;
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Bench for the cache AXI read arbiter: a table of single bursts driven
// through grant, AR stall and R beats, plus hand-written sequences for
// back-to-back round-robin, R back-pressure, stray beats and mid-burst reset.
module tb_cache_axi_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_ar_valid, ic_ar_ready, ic_r_valid, ic_r_ready, ic_r_last;
  logic [AW-1:0] ic_ar_addr;
  logic [LW-1:0] ic_ar_len;
  logic [DW-1:0] ic_r_data;
  logic          dc_ar_valid, dc_ar_ready, dc_r_valid, dc_r_ready, dc_r_last;
  logic [AW-1:0] dc_ar_addr;
  logic [LW-1:0] dc_ar_len;
  logic [DW-1:0] dc_r_data;
  logic          m_ar_valid, m_ar_ready, m_ar_id, m_r_valid, m_r_ready, m_r_last;
  logic [AW-1:0] m_ar_addr;
  logic [LW-1:0] m_ar_len;
  logic [DW-1:0] m_r_data;

  always #5 clk = ~clk;

  cache_axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_ar_valid(ic_ar_valid), .ic_ar_ready(ic_ar_ready),
    .ic_ar_addr(ic_ar_addr), .ic_ar_len(ic_ar_len),
    .ic_r_valid(ic_r_valid), .ic_r_ready(ic_r_ready),
    .ic_r_data(ic_r_data), .ic_r_last(ic_r_last),
    .dc_ar_valid(dc_ar_valid), .dc_ar_ready(dc_ar_ready),
    .dc_ar_addr(dc_ar_addr), .dc_ar_len(dc_ar_len),
    .dc_r_valid(dc_r_valid), .dc_r_ready(dc_r_ready),
    .dc_r_data(dc_r_data), .dc_r_last(dc_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_r_data(m_r_data), .m_r_last(m_r_last)
  );

  typedef struct {
    bit            req_ic;
    bit            req_dc;
    logic [AW-1:0] ic_addr;
    logic [LW-1:0] ic_len;
    logic [AW-1:0] dc_addr;
    logic [LW-1:0] dc_len;
    int            ar_wait;
    bit            exp_id;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_len;
  } vec_t;

  typedef struct {
    bit            id;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  typedef struct {
    bit id;
    int cyc;
  } grant_t;

  vec_t   vt[7];
  beat_t  sbq[$];
  grant_t gq[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_ar_valid = 0; ic_ar_addr = '0; ic_ar_len = '0; ic_r_ready = 0;
    dc_ar_valid = 0; dc_ar_addr = '0; dc_ar_len = '0; dc_r_ready = 0;
    m_ar_ready = 0; m_r_valid = 0; m_r_data = '0; m_r_last = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    step();
    step();
    rst = 0;
  endtask

  // Pop the expected beat and compare it against what the owner sees.
  task automatic mon_beat();
    beat_t e;
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk("beat_valid", e.id ? dc_r_valid : ic_r_valid, 1);
    chk("beat_other_valid", e.id ? ic_r_valid : dc_r_valid, 0);
    chk("beat_data", e.id ? dc_r_data : ic_r_data, e.data);
    chk("beat_last", e.id ? dc_r_last : ic_r_last, e.last);
  endtask

  task automatic push_beat(input bit id, input logic [DW-1:0] d, input bit last);
    beat_t b;
    b.id = id; b.data = d; b.last = last;
    sbq.push_back(b);
  endtask

  task automatic run_vec(input vec_t v);
    logic [DW-1:0] d;
    ic_ar_valid = v.req_ic; ic_ar_addr = v.ic_addr; ic_ar_len = v.ic_len;
    dc_ar_valid = v.req_dc; dc_ar_addr = v.dc_addr; dc_ar_len = v.dc_len;
    #2;
    chk("grant_ic", ic_ar_ready, !v.exp_id && v.req_ic);
    chk("grant_dc", dc_ar_ready, v.exp_id && v.req_dc);
    chk("idle_ar_valid", m_ar_valid, 0);
    step();
    // Requester withdraws and scrambles its fields: latched values must hold.
    ic_ar_valid = 0; dc_ar_valid = 0;
    ic_ar_addr = 32'hFFFF_FFFF; dc_ar_addr = 32'hEEEE_EEEE;
    ic_ar_len = 8'hFF; dc_ar_len = 8'hEE;
    for (int k = 0; k <= v.ar_wait; k++) begin
      m_ar_ready = (k == v.ar_wait);
      #2;
      chk("ar_valid", m_ar_valid, 1);
      chk("ar_addr", m_ar_addr, v.exp_addr);
      chk("ar_len", m_ar_len, v.exp_len);
      chk("ar_id", m_ar_id, v.exp_id);
      chk("ar_ready_blocked", {ic_ar_ready, dc_ar_ready}, 0);
      chk("ar_phase_r_ready", m_r_ready, 0);
      step();
    end
    m_ar_ready = 0;
    for (int b = 0; b <= int'(v.exp_len); b++) begin
      d = {$urandom, $urandom};
      if (v.exp_id) begin
        dc_r_ready = 1; ic_r_ready = 1'($urandom_range(0, 1));
      end else begin
        ic_r_ready = 1; dc_r_ready = 1'($urandom_range(0, 1));
      end
      m_r_valid = 1; m_r_data = d; m_r_last = (b == int'(v.exp_len));
      push_beat(v.exp_id, d, m_r_last);
      #2;
      chk("data_r_ready", m_r_ready, 1);
      mon_beat();
      step();
    end
    m_r_valid = 0; m_r_last = 0; ic_r_ready = 0; dc_r_ready = 0;
    #2;
    chk("back_idle_ar_valid", m_ar_valid, 0);
    chk("back_idle_r_ready", m_r_ready, 0);
    step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ic dc ic_addr       ic_len dc_addr       dc_len wait id exp_addr     exp_len
    vt[0] = '{1, 0, 32'h0000_1000, 8'd3, 32'h0000_DEAD, 8'd7, 0, 0, 32'h0000_1000, 8'd3};
    vt[1] = '{1, 1, 32'h0000_2000, 8'd0, 32'h0000_3000, 8'd1, 5, 1, 32'h0000_3000, 8'd1};
    vt[2] = '{1, 1, 32'h0000_2040, 8'd2, 32'h0000_3040, 8'd0, 2, 0, 32'h0000_2040, 8'd2};
    vt[3] = '{1, 0, 32'h0000_4000, 8'd1, 32'h0000_0000, 8'd0, 1, 0, 32'h0000_4000, 8'd1};
    vt[4] = '{0, 1, 32'h0000_0000, 8'd0, 32'h0000_5000, 8'd0, 0, 1, 32'h0000_5000, 8'd0};
    vt[5] = '{0, 1, 32'h0000_0000, 8'd0, 32'h0000_5100, 8'd2, 3, 1, 32'h0000_5100, 8'd2};
    vt[6] = '{1, 1, 32'h0000_6000, 8'd0, 32'h0000_6100, 8'd3, 0, 0, 32'h0000_6000, 8'd0};

    do_reset();
    #2;
    chk("rst_ar_valid", m_ar_valid, 0);
    chk("rst_r_ready", m_r_ready, 0);
    chk("rst_ar_ready", {ic_ar_ready, dc_ar_ready}, 0);
    chk("rst_r_valid", {ic_r_valid, dc_r_valid}, 0);
    chk("rst_ar_fields", {m_ar_addr, m_ar_len, m_ar_id}, 0);
    step();

    // Stray R beat while idle is not accepted or forwarded.
    m_r_valid = 1; m_r_last = 1; m_r_data = 64'h1234; ic_r_ready = 1; dc_r_ready = 1;
    #2;
    chk("idle_stray_r_ready", m_r_ready, 0);
    chk("idle_stray_r_valid", {ic_r_valid, dc_r_valid}, 0);
    step();
    idle_inputs();
    step();

    foreach (vt[i]) run_vec(vt[i]);

    // dcache burst with owner back-pressure 1,0,1.
    dc_ar_valid = 1; dc_ar_addr = 32'h7000; dc_ar_len = 8'd1;
    #2; chk("bp_grant_dc", dc_ar_ready, 1);
    step();
    dc_ar_valid = 0; m_ar_ready = 1;
    #2; chk("bp_ar_valid", m_ar_valid, 1);
    step();
    m_ar_ready = 0;
    dc_r_ready = 1; m_r_valid = 1; m_r_data = 64'hAAAA_0001; m_r_last = 0;
    push_beat(1, m_r_data, 0);
    #2; chk("bp_r_ready_1", m_r_ready, 1); mon_beat(); chk("bp_ic_quiet_1", ic_r_valid, 0);
    step();
    dc_r_ready = 0; m_r_data = 64'hAAAA_0002; m_r_last = 1;
    #2; chk("bp_r_ready_0", m_r_ready, 0); chk("bp_dc_valid_0", dc_r_valid, 1);
    chk("bp_ic_quiet_0", ic_r_valid, 0);
    step();
    dc_r_ready = 1;
    push_beat(1, m_r_data, 1);
    #2; chk("bp_r_ready_2", m_r_ready, 1); mon_beat(); chk("bp_ic_quiet_2", ic_r_valid, 0);
    step();
    idle_inputs();
    #2; chk("bp_end_r_ready", m_r_ready, 0); chk("bp_end_ar_valid", m_ar_valid, 0);
    step();

    // Both requesters held high from reset with single-beat bursts.
    do_reset();
    ic_ar_valid = 1; ic_ar_addr = 32'hA000; ic_ar_len = 0;
    dc_ar_valid = 1; dc_ar_addr = 32'hB000; dc_ar_len = 0;
    m_ar_ready = 1; m_r_valid = 1; m_r_last = 1; ic_r_ready = 1; dc_r_ready = 1;
    for (int c = 0; c < 12; c++) begin
      grant_t g;
      #2;
      if (ic_ar_ready && dc_ar_ready) chk("rr_double_grant", 1, 0);
      if (ic_ar_ready || dc_ar_ready) begin
        g.id = dc_ar_ready; g.cyc = c;
        gq.push_back(g);
      end
      step();
    end
    idle_inputs();
    chk("rr_grant_count", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      chk("rr_grant_id", gq[i].id, i % 2);
      chk("rr_grant_cycle", gq[i].cyc, 3 * i);
    end
    step();
    step();

    // Reset on beat 2 of a 4-beat icache burst with both caches waiting.
    do_reset();
    ic_ar_valid = 1; ic_ar_addr = 32'h8000; ic_ar_len = 8'd3;
    #2; chk("mr_grant_ic", ic_ar_ready, 1);
    step();
    ic_ar_valid = 0; dc_ar_valid = 1; dc_ar_addr = 32'h9000; dc_ar_len = 8'd2;
    m_ar_ready = 1;
    #2; chk("mr_ar_valid", m_ar_valid, 1); chk("mr_dc_blocked_addr", dc_ar_ready, 0);
    step();
    m_ar_ready = 0;
    ic_r_ready = 1; m_r_valid = 1; m_r_data = 64'hBEEF_0001; m_r_last = 0;
    push_beat(0, m_r_data, 0);
    #2; mon_beat(); chk("mr_dc_blocked_data", dc_ar_ready, 0);
    step();
    rst = 1; m_r_data = 64'hBEEF_0002;
    step();
    ic_ar_valid = 1; ic_ar_addr = 32'h8800; ic_ar_len = 8'd1;
    #2;
    chk("mr_rst_ar_valid", m_ar_valid, 0);
    chk("mr_rst_r_ready", m_r_ready, 0);
    chk("mr_rst_ar_ready", {ic_ar_ready, dc_ar_ready}, 0);
    chk("mr_rst_r_valid", {ic_r_valid, dc_r_valid}, 0);
    chk("mr_rst_ar_fields", {m_ar_addr, m_ar_len, m_ar_id}, 0);
    step();
    rst = 0;
    #2;
    chk("mr_post_grant_ic", ic_ar_ready, 1);
    chk("mr_post_grant_dc", dc_ar_ready, 0);
    step();
    ic_ar_valid = 0; dc_ar_valid = 0; m_r_valid = 0;
    #2;
    chk("mr_post_ar_valid", m_ar_valid, 1);
    chk("mr_post_ar_id", m_ar_id, 0);
    chk("mr_post_ar_addr", m_ar_addr, 32'h8800);
    step();

    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
